fft_frame_streamer: RTL and testbench

//  Upstream feeder of the FFT core that drives the biometrics path.
//  - Takes the 16-bit mic sample strobe and applies first-order pre-emphasis.
//  - Packs FRAME_LEN-sample frames into a ping-pong buffer.
//  - Streams each full frame to the FFT as AXI-Stream beats {imag=0, real}, with last on the final beat.
//  - Decouples the bursty FFT backpressure from the steady audio rate.

---
 rtl/fft_frame_streamer.sv | 143 ++++++++++++++
 tb/tb_fft_frame_streamer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_streamer.sv
// Pre-emphasis front end that packs audio into ping-pong frame banks and
// streams each complete frame to the FFT core over AXI-Stream.
module fft_frame_streamer #(
    parameter int unsigned FRAME_LEN     = 1024,
    parameter int unsigned SAMPLE_WIDTH  = 16,
    parameter int unsigned PREEMPH_SHIFT = 5
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic                           enable_in,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                           sample_valid_in,
    output logic [2*SAMPLE_WIDTH-1:0]      fft_data_out,
    output logic                           fft_valid_out,
    output logic                           fft_last_out,
    input  logic                           fft_ready_in,
    output logic                           dropped_out
);

    localparam int unsigned IDX_W = $clog2(FRAME_LEN);
    localparam int unsigned EXT_W = SAMPLE_WIDTH + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic signed [EXT_W-1:0] Y_MAX = {3'b000, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] Y_MIN = {3'b111, {(SAMPLE_WIDTH-1){1'b0}}};

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    logic signed [SAMPLE_WIDTH-1:0] x_prev;
    logic signed [EXT_W-1:0]        x_ext, p_ext, y_ext;
    logic signed [SAMPLE_WIDTH-1:0] y_sat;

    logic             wbank, rbank, rbank_n;
    logic [IDX_W-1:0] widx, ridx, ridx_n;
    logic [1:0]       full;
    logic [0:0]       state, state_n;
    logic             wr_en, frame_done, fire, release_bank;
    logic             dropped;

    logic [SAMPLE_WIDTH-1:0] mem [2*FRAME_LEN];
    logic [SAMPLE_WIDTH-1:0] mem_q;

    always_comb begin
        x_ext = EXT_W'(sample_in);
        p_ext = EXT_W'(x_prev);
        y_ext = x_ext - p_ext + (p_ext >>> PREEMPH_SHIFT);
        if (y_ext > Y_MAX)
            y_sat = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
        else if (y_ext < Y_MIN)
            y_sat = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
        else
            y_sat = y_ext[SAMPLE_WIDTH-1:0];
    end

    assign wr_en      = rst_n_in && enable_in && sample_valid_in && !full[wbank];
    assign frame_done = wr_en && (widx == LAST_IDX);

    always_ff @(posedge clk_in) begin
        if (wr_en)
            mem[{wbank, widx}] <= y_sat;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            wbank   <= 1'b0;
            widx    <= '0;
            x_prev  <= '0;
            dropped <= 1'b0;
        end else begin
            dropped <= 1'b0;
            if (!enable_in) begin
                widx   <= '0;
                x_prev <= '0;
            end else if (sample_valid_in) begin
                x_prev <= sample_in;
                if (full[wbank])
                    dropped <= 1'b1;
                else if (widx == LAST_IDX) begin
                    widx  <= '0;
                    wbank <= ~wbank;
                end else
                    widx <= widx + 1'b1;
            end
        end
    end

    // Set and clear always address different banks, so both may fire together.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in)
            full <= '0;
        else begin
            if (frame_done)
                full[wbank] <= 1'b1;
            if (release_bank)
                full[rbank] <= 1'b0;
        end
    end

    assign fire = (state == S_STREAM) && fft_ready_in;

    always_comb begin
        state_n      = state;
        rbank_n      = rbank;
        ridx_n       = ridx;
        release_bank = 1'b0;
        if (state == S_IDLE) begin
            if (full[rbank]) begin
                state_n = S_STREAM;
                ridx_n  = '0;
            end
        end else if (fire) begin
            if (ridx == LAST_IDX) begin
                release_bank = 1'b1;
                rbank_n      = ~rbank;
                ridx_n       = '0;
                state_n      = full[~rbank] ? S_STREAM : S_IDLE;
            end else
                ridx_n = ridx + 1'b1;
        end
    end

    // Reading at the next-cycle address keeps the RAM output register aligned
    // with the presented beat, so it doubles as the stall-holding register.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state <= S_IDLE;
            rbank <= 1'b0;
            ridx  <= '0;
            mem_q <= '0;
        end else begin
            state <= state_n;
            rbank <= rbank_n;
            ridx  <= ridx_n;
            mem_q <= mem[{rbank_n, ridx_n}];
        end
    end

    assign fft_valid_out = (state == S_STREAM);
    assign fft_last_out  = (state == S_STREAM) && (ridx == LAST_IDX);
    assign fft_data_out  = {{SAMPLE_WIDTH{1'b0}}, mem_q};
    assign dropped_out   = dropped;

endmodule

// File: tb/tb_fft_frame_streamer.sv
// Randomized self-checking bench for fft_frame_streamer (FRAME_LEN=8) against
// a frame-level reference model of pre-emphasis, buffering and streaming.
module tb_fft_frame_streamer;

    localparam int FL = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               enable = 1'b0;
    logic signed [15:0] sample = '0;
    logic               sample_valid = 1'b0;
    logic [31:0]        fft_data;
    logic               fft_valid, fft_last, fft_ready = 1'b0, dropped;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [15:0] exp_q[$];
    logic [15:0] cur[$];
    logic [31:0] obs[$];
    int xp = 0, pending = 0, bif = 0;
    int nbeats = 0, nlasts = 0, ndrops = 0, exp_drops = 0;
    int ready_mode = 0;
    logic        prev_stall = 1'b0, prev_last = 1'b0;
    logic [31:0] prev_data = '0;

    fft_frame_streamer #(
        .FRAME_LEN(FL),
        .SAMPLE_WIDTH(16),
        .PREEMPH_SHIFT(5)
    ) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .enable_in(enable),
        .sample_in(sample),
        .sample_valid_in(sample_valid),
        .fft_data_out(fft_data),
        .fft_valid_out(fft_valid),
        .fft_last_out(fft_last),
        .fft_ready_in(fft_ready),
        .dropped_out(dropped)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pe(input int x, input int p);
        int y;
        y = x - p + (p >>> 5);
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
        return y;
    endfunction

    always begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       fft_ready = 1'b0;
            1:       fft_ready = 1'b1;
            default: fft_ready = 1'($urandom % 2);
        endcase
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("hold_valid", {31'b0, fft_valid}, 32'd1);
                check_eq("hold_data", fft_data, prev_data);
                check_eq("hold_last", {31'b0, fft_last}, {31'b0, prev_last});
            end
            if (dropped) ndrops++;
            if (fft_valid && fft_ready) begin
                check_eq("beat_avail", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    check_eq("beat_data", fft_data, {16'h0000, e});
                    check_eq("beat_last", {31'b0, fft_last}, {31'b0, bif == FL - 1});
                    obs.push_back(fft_data);
                    nbeats++;
                    if (fft_last) nlasts++;
                    if (bif == FL - 1) begin
                        bif = 0;
                        pending--;
                    end else
                        bif++;
                end
            end
            prev_stall = fft_valid && !fft_ready;
            prev_data  = fft_data;
            prev_last  = fft_last;
        end
    end

    task automatic send(input logic signed [15:0] x);
        @(posedge clk);
        #1;
        sample = x;
        sample_valid = 1'b1;
        if (enable) begin
            if (pending == 2 && cur.size() == 0)
                exp_drops++;
            else begin
                cur.push_back(16'(pe(int'(x), xp)));
                if (cur.size() == FL) begin
                    foreach (cur[i]) exp_q.push_back(cur[i]);
                    cur.delete();
                    pending++;
                end
            end
            xp = int'(x);
        end
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || fft_valid) && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_eq("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, lat, d0, t;
        logic [31:0] tbl[FL];

        idle(3);
        check_eq("rst_valid", {31'b0, fft_valid}, 32'd0);
        check_eq("rst_last", {31'b0, fft_last}, 32'd0);
        check_eq("rst_drop", {31'b0, dropped}, 32'd0);
        check_eq("rst_data", fft_data, 32'd0);
        rst_n = 1'b1;
        enable = 1'b1;
        ready_mode = 1;
        idle(2);

        // Constant input: step response of the pre-emphasis filter
        base = nbeats;
        for (int i = 0; i < FL; i++) send(16'sd1000);
        lat = 1;
        while (!fft_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("latency_le4", {31'b0, lat <= 4}, 32'd1);
        drain();
        tbl[0] = 32'd1000;
        for (int i = 1; i < FL; i++) tbl[i] = 32'd31;
        for (int i = 0; i < FL; i++) check_eq("const_beat", obs[base + i], tbl[i]);
        check_eq("const_lasts", nlasts, 32'd1);

        // Saturation in both directions
        base = nbeats;
        send(-16'sd32768);
        send(16'sd32767);
        send(16'sd32767);
        send(-16'sd32768);
        for (int i = 0; i < 4; i++) send(16'($urandom));
        drain();
        check_eq("sat_pos", obs[base + 1], 32'h0000_7fff);
        check_eq("sat_neg", obs[base + 3], 32'h0000_8000);

        // Two random frames with random backpressure and sample spacing
        base = nbeats;
        d0 = nlasts;
        ready_mode = 2;
        for (int i = 0; i < 2 * FL; i++) begin
            send(16'($urandom));
            idle(int'($urandom_range(0, 2)));
        end
        drain();
        check_eq("rand_beats", nbeats - base, 32'd16);
        check_eq("rand_lasts", nlasts - d0, 32'd2);

        // Both banks full with no ready: third frame is dropped
        ready_mode = 0;
        idle(2);
        base = nbeats;
        d0 = ndrops;
        for (int i = 0; i < 3 * FL; i++) send(16'($urandom));
        idle(3);
        check_eq("stall_no_beats", nbeats - base, 32'd0);
        check_eq("drop_count", ndrops - d0, 32'd8);
        check_eq("drop_model", exp_drops, 32'd8);
        d0 = nlasts;
        ready_mode = 1;
        drain();
        check_eq("backlog_beats", nbeats - base, 32'd16);
        check_eq("backlog_lasts", nlasts - d0, 32'd2);

        // Reset mid-stream at beat 3 of a frame
        d0 = nbeats;
        for (int i = 0; i < FL; i++) send(16'($urandom));
        t = 0;
        while (nbeats < d0 + 3 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_eq("reach_beat3", {31'b0, nbeats >= d0 + 3}, 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        cur.delete();
        xp = 0;
        pending = 0;
        bif = 0;
        @(posedge clk);
        @(negedge clk);
        check_eq("midrst_valid", {31'b0, fft_valid}, 32'd0);
        check_eq("midrst_last", {31'b0, fft_last}, 32'd0);
        check_eq("midrst_drop", {31'b0, dropped}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        base = nbeats;
        d0 = nlasts;
        send(16'sd1234);
        for (int i = 1; i < FL; i++) send(16'($urandom));
        drain();
        check_eq("post_rst_first", obs[base], 32'd1234);
        check_eq("post_rst_lasts", nlasts - d0, 32'd1);

        // enable low mid-frame discards the partial frame
        base = nbeats;
        d0 = nlasts;
        t = ndrops;
        for (int i = 0; i < 5; i++) send(16'($urandom));
        enable = 1'b0;
        cur.delete();
        xp = 0;
        send(16'sd777);
        idle(3);
        enable = 1'b1;
        send(-16'sd2500);
        for (int i = 1; i < FL; i++) send(16'($urandom));
        drain();
        check_eq("en_first_raw", obs[base], 32'h0000_f63c);
        check_eq("en_one_frame", nlasts - d0, 32'd1);
        check_eq("en_beats", nbeats - base, 32'd8);
        check_eq("en_no_drops", ndrops - t, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
